controle_botoes: RTL and testbench
==================================

CONTROLE_BOTOES -- requirements
Module: controle_botoes

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent button channels, 1..16.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: input synchronizer depth, 2..4.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles needed to accept a new level, 1..65535.
REQ-004 SHALL have port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port btn_in, input, N_CH bits: raw asynchronous button levels, 1 = pressed.
REQ-007 SHALL have port mode, input, 2 bits: global channel mode; 00 LATCH, 01 TOGGLE, 10 FOLLOW, 11 reserved.
REQ-008 SHALL have port clear, input, N_CH bits: synchronous per-channel clear of started.
REQ-009 SHALL have port level, output, N_CH bits: debounced button level.
REQ-010 SHALL have port pulse, output, N_CH bits: one-cycle press strobe.
REQ-011 SHALL have port started, output, N_CH bits: per-channel run flag.

Function
REQ-012 SHALL pass each btn_in bit through its own SYNC_STAGES-flop synchronizer before any other use.
REQ-013 SHALL keep one debounce counter per channel, width clog2(DEBOUNCE_CYCLES+1): zeroed while synced value equals level, incremented while it differs.
REQ-014 SHALL set level to the synced value, and zero the counter, on the edge where the counter would reach DEBOUNCE_CYCLES; any mismatch gap shorter than that restarts the count.
REQ-015 SHALL give a latency of exactly SYNC_STAGES+DEBOUNCE_CYCLES clk edges from the first edge sampling a new stable btn_in value to level changing.
REQ-016 SHALL assert pulse[i] (registered) for exactly one cycle, on the edge after level[i] rises; never on a fall.
REQ-017 SHALL update started[i] on the same edge pulse[i] is asserted: LATCH sets it to 1; TOGGLE inverts it; reserved behaves as LATCH.
REQ-018 SHALL in FOLLOW mode drive started[i] from level[i], with one cycle of delay, and ignore clear.
REQ-019 SHALL give clear[i] priority over a simultaneous press in LATCH/TOGGLE: started[i] goes to 0.
REQ-020 SHALL sample mode each cycle; a mode change SHALL NOT alter started until the next press or, for FOLLOW, the next edge.
REQ-021 SHALL keep channels fully independent; simultaneous presses on several channels each produce their own pulse.

Reset
REQ-022 SHALL on reset assertion immediately clear synchronizers, counters, level, pulse and started to 0, regardless of clk.
REQ-023 SHALL treat a button held through reset release as a new press: it produces one pulse after full latency.

Structure
REQ-024 SHALL place the mode encodings (MODE_LATCH, MODE_TOGGLE, MODE_FOLLOW) and the parameter defaults in shared package controle_pkg.
REQ-025 SHALL implement the synchronizer and debounce for one channel in sub-module debounce_canal, instantiated N_CH times by a generate loop.

Verification (N_CH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
REQ-026 LATCH: btn_in[0] rises and holds -> level[0]=1 after 6 edges, pulse[0]=1 for one cycle at edge 7, started[0]=1 from edge 7 until clear[0].
REQ-027 Bounce: btn_in[1] toggles 1,0,1 at 1-cycle intervals, then holds 1 -> single pulse[1] only, timed from the last rise; a 3-cycle glitch -> no level change.
REQ-028 TOGGLE: three clean presses on ch2 -> started[2] sequence 1,0,1; clear[2] in the same cycle as the 4th pulse -> started[2]=0.
REQ-029 FOLLOW: hold btn_in[3] for 20 cycles -> started[3] tracks level[3] with 1-cycle lag; clear[3] has no effect.
REQ-030 Reset mid-count: assert reset at counter=2 -> all outputs 0 at once; with the button still held at release, pulse comes 7 edges later.
REQ-031 Simultaneous: all 4 btn_in rise together -> pulse=4'b1111 for one cycle and started=4'b1111 in LATCH.

Source files
------------

// File: rtl/controle_pkg.sv
// Shared mode encodings, parameter defaults and the started-flag update rule
// for the button controller.
package controle_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_LATCH  = 2'b00;
  localparam mode_t MODE_TOGGLE = 2'b01;
  localparam mode_t MODE_FOLLOW = 2'b10;

  localparam int N_CH_DEF            = 4;
  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 16;

  // Reserved encoding falls into the default arm and behaves as LATCH.
  function automatic logic started_next(input mode_t mode, input logic rise,
                                        input logic clr, input logic lvl,
                                        input logic cur);
    logic nxt;
    nxt = cur;
    case (mode)
      MODE_FOLLOW: nxt = lvl;
      MODE_TOGGLE: begin
        if (clr) nxt = 1'b0;
        else if (rise) nxt = ~cur;
        else nxt = cur;
      end
      default: begin
        if (clr) nxt = 1'b0;
        else if (rise) nxt = 1'b1;
        else nxt = cur;
      end
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/debounce_canal.sv
// One button channel: multi-flop synchronizer followed by a stable-count
// debouncer that only accepts a level after DEBOUNCE_CYCLES matching samples.
module debounce_canal
  import controle_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic btn_i,
  output logic level_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic                   level_q, level_d;
  logic                   synced;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], btn_i};
    synced  = sync_q[SYNC_STAGES-1];
    cnt_inc = cnt_q + CNT_W'(1);
    level_d = level_q;
    cnt_d   = '0;
    if (synced == level_q) begin
      cnt_d   = '0;
      level_d = level_q;
    end else if (cnt_inc == CNT_MAX) begin
      // Accept the new level on the edge the count would reach the target.
      cnt_d   = '0;
      level_d = synced;
    end else begin
      cnt_d   = cnt_inc;
      level_d = level_q;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/controle_botoes.sv
// Multi-channel button controller: debounced level, one-cycle press pulse and
// a per-channel started flag governed by the global mode.
module controle_botoes
  import controle_pkg::*;
#(
  parameter int N_CH            = N_CH_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] btn_in,
  input  logic [1:0]      mode,
  input  logic [N_CH-1:0] clear,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] pulse,
  output logic [N_CH-1:0] started
);

  logic [N_CH-1:0] level_s;
  logic [N_CH-1:0] level_dly_q;
  logic [N_CH-1:0] rise_s;
  logic [N_CH-1:0] pulse_q, pulse_d;
  logic [N_CH-1:0] started_q, started_d;

  for (genvar g = 0; g < N_CH; g++) begin : g_canal
    debounce_canal #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_canal (
      .clk_i  (clk),
      .reset_i(reset),
      .btn_i  (btn_in[g]),
      .level_o(level_s[g])
    );
  end

  always_comb begin
    rise_s    = level_s & ~level_dly_q;
    pulse_d   = rise_s;
    started_d = started_q;
    for (int i = 0; i < N_CH; i++) begin
      started_d[i] = started_next(mode, rise_s[i], clear[i], level_s[i], started_q[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_dly_q <= '0;
      pulse_q     <= '0;
      started_q   <= '0;
    end else begin
      level_dly_q <= level_s;
      pulse_q     <= pulse_d;
      started_q   <= started_d;
    end
  end

  assign level   = level_s;
  assign pulse   = pulse_q;
  assign started = started_q;

endmodule

// File: tb/tb_controle_botoes.sv
// Self-checking bench for controle_botoes: sliding-window reference model plus
// directed literal checks and a randomized phase.
module tb_controle_botoes;

  localparam int N_CH = 4;
  localparam int S    = 2;
  localparam int D    = 4;
  localparam int MAXE = 2047;

  logic            clk;
  logic            reset;
  logic [N_CH-1:0] btn_in;
  logic [1:0]      mode;
  logic [N_CH-1:0] clear;
  logic [N_CH-1:0] level;
  logic [N_CH-1:0] pulse;
  logic [N_CH-1:0] started;

  int errors;
  int n_checks;

  // model: edge index since reset, sampled buttons and level after each edge
  int              t;
  logic [N_CH-1:0] hist [0:MAXE];
  logic [N_CH-1:0] lvlh [0:MAXE];
  logic [N_CH-1:0] m_pulse;
  logic [N_CH-1:0] m_started;

  controle_botoes #(
    .N_CH           (N_CH),
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .btn_in (btn_in),
    .mode   (mode),
    .clear  (clear),
    .level  (level),
    .pulse  (pulse),
    .started(started)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (edge %0d)", name, act, exp, t);
    end
  endtask

  task automatic model_reset();
    t         = 0;
    hist[0]   = '0;
    lvlh[0]   = '0;
    m_pulse   = '0;
    m_started = '0;
  endtask

  // Level flips once D consecutive synchronized samples all disagree with it.
  task automatic model_edge();
    logic [N_CH-1:0] nl;
    logic p1, p2, obs, fl;
    int src;
    if (t < MAXE) t++;
    else begin
      n_checks++;
      errors++;
      $display("FAIL model_range: actual=%0d required<%0d", t, MAXE);
    end
    hist[t] = btn_in;
    for (int i = 0; i < N_CH; i++) begin
      fl = 1'b1;
      for (int u = t - D + 1; u <= t; u++) begin
        src = u - S;
        obs = (src >= 1) ? hist[src][i] : 1'b0;
        if (obs == lvlh[t-1][i]) fl = 1'b0;
      end
      nl[i] = fl ? ~lvlh[t-1][i] : lvlh[t-1][i];
      p1 = lvlh[t-1][i];
      p2 = (t >= 2) ? lvlh[t-2][i] : 1'b0;
      m_pulse[i] = p1 & ~p2;
      if (mode == 2'b10) m_started[i] = p1;
      else if (clear[i]) m_started[i] = 1'b0;
      else if (m_pulse[i]) m_started[i] = (mode == 2'b01) ? ~m_started[i] : 1'b1;
      else m_started[i] = m_started[i];
    end
    lvlh[t] = nl;
  endtask

  // One clock edge: update the model, compare all outputs, return at negedge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("cmp_level", level, lvlh[t]);
    check("cmp_pulse", pulse, m_pulse);
    check("cmp_started", started, m_started);
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    check("rst_level", level, 0);
    check("rst_pulse", pulse, 0);
    check("rst_started", started, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int pcnt, pedge, low_seen;
    logic exp_tog [0:2];
    errors   = 0;
    n_checks = 0;
    reset    = 1'b1;
    btn_in   = '0;
    mode     = 2'b00;
    clear    = '0;
    model_reset();
    @(negedge clk);

    // LATCH on channel 0
    do_reset();
    mode   = 2'b00;
    btn_in = 4'b0001;
    for (int e = 1; e <= 8; e++) begin
      step();
      if (e == 5) check("A_level_e5", level[0], 0);
      if (e == 6) begin
        check("A_level_e6", level[0], 1);
        check("A_pulse_e6", pulse[0], 0);
      end
      if (e == 7) begin
        check("A_pulse_e7", pulse[0], 1);
        check("A_started_e7", started[0], 1);
      end
      if (e == 8) begin
        check("A_pulse_e8", pulse[0], 0);
        check("A_started_e8", started[0], 1);
      end
    end
    repeat (3) step();
    clear = 4'b0001;
    step();
    check("A_clear", started[0], 0);
    clear  = 4'b0000;
    btn_in = 4'b0000;
    repeat (8) step();
    btn_in = 4'b0001;
    repeat (6) step();
    clear = 4'b0001;
    step();
    check("A_prio_pulse", pulse[0], 1);
    check("A_prio_started", started[0], 0);
    clear = 4'b0000;
    step();

    // Bounce on channel 1, then a short glitch
    do_reset();
    pcnt  = 0;
    pedge = 0;
    for (int e = 1; e <= 20; e++) begin
      btn_in = (e == 2) ? 4'b0000 : 4'b0010;
      step();
      if (pulse[1]) begin
        pcnt++;
        pedge = e;
      end
    end
    check("B_pulse_count", pcnt, 1);
    check("B_pulse_edge", pedge, 9);
    low_seen = 0;
    btn_in   = 4'b0000;
    repeat (3) step();
    btn_in = 4'b0010;
    for (int e = 0; e < 15; e++) begin
      step();
      if (!level[1]) low_seen++;
    end
    check("B_glitch_level", low_seen, 0);

    // TOGGLE on channel 2
    do_reset();
    mode       = 2'b01;
    exp_tog[0] = 1'b1;
    exp_tog[1] = 1'b0;
    exp_tog[2] = 1'b1;
    for (int p = 0; p < 3; p++) begin
      btn_in = 4'b0100;
      repeat (7) step();
      check("C_toggle", started[2], exp_tog[p]);
      repeat (5) step();
      btn_in = 4'b0000;
      repeat (8) step();
    end
    btn_in = 4'b0100;
    repeat (6) step();
    clear = 4'b0100;
    step();
    check("C_clr_pulse", pulse[2], 1);
    check("C_clr_started", started[2], 0);
    clear = 4'b0000;
    step();

    // FOLLOW on channel 3 with clear held high
    do_reset();
    mode  = 2'b10;
    clear = 4'b1000;
    for (int e = 1; e <= 32; e++) begin
      btn_in = (e <= 20) ? 4'b1000 : 4'b0000;
      step();
      if (e == 6) check("D_started_e6", started[3], 0);
      if (e == 7) check("D_started_e7", started[3], 1);
      if (e == 26) check("D_started_e26", started[3], 1);
      if (e == 27) check("D_started_e27", started[3], 0);
    end
    clear = 4'b0000;

    // Reset in the middle of a count
    do_reset();
    mode   = 2'b00;
    btn_in = 4'b1000;
    repeat (8) step();
    btn_in = 4'b1001;
    repeat (4) step();
    check("E_pre_level", level, 4'b1000);
    do_reset();
    repeat (6) step();
    check("E_pulse_e6", pulse, 0);
    step();
    check("E_pulse_e7", pulse, 4'b1001);

    // Simultaneous presses
    do_reset();
    mode   = 2'b00;
    btn_in = 4'b1111;
    repeat (7) step();
    check("F_pulse", pulse, 4'b1111);
    check("F_started", started, 4'b1111);
    step();
    check("F_pulse_after", pulse, 0);

    // Randomized phase
    do_reset();
    for (int k = 0; k < 800; k++) begin
      if (k == 400) do_reset();
      if (k % 50 == 0) mode = 2'($urandom_range(0, 3));
      for (int i = 0; i < N_CH; i++) begin
        if ($urandom_range(0, 7) == 0) btn_in[i] = ~btn_in[i];
        clear[i] = ($urandom_range(0, 15) == 0);
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule
